// File: rtl/peak_finder.sv
// Peak finder for a signed filter-output stream.
// Detects excursions strictly above a trigger level, tracks the maximum sample
// and its timestamp, and reports amplitude, time, width and a pile-up flag
// one cycle after the event terminates. A dead-time and a re-arm condition
// stop the tail of one pulse from being reported as a new event.
module peak_finder #(
  parameter int DATA_W    = 16,
  parameter int TIME_W    = 16,
  parameter int WIDTH_W   = 8,
  parameter int HOLDOFF   = 8,
  parameter int MAX_WIDTH = 200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic [TIME_W-1:0]        peak_time,
  output logic [WIDTH_W-1:0]       peak_width,
  output logic                     pileup,
  output logic [15:0]              event_count
);

  // Pile-up limit expressed in the width counter's own width.
  localparam logic [WIDTH_W-1:0] MAX_W = WIDTH_W'(MAX_WIDTH);

  // Dead-time counter counts HOLDOFF-1 down to 0, giving HOLDOFF cycles.
  localparam int                 HOLD_CW   = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_CW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HOLD_CW'(HOLDOFF - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HOLDOFF,
    ST_REARM
  } state_t;

  // With no dead-time a report goes straight to waiting for a sub-threshold sample.
  localparam state_t POST_REPORT = (HOLDOFF > 0) ? ST_HOLDOFF : ST_REARM;

  state_t                     state;
  state_t                     state_next;

  logic [TIME_W-1:0]          ts;
  logic signed [DATA_W-1:0]   thr_l;
  logic signed [DATA_W-1:0]   cur_max;
  logic [TIME_W-1:0]          cur_tmax;
  logic [WIDTH_W-1:0]         cur_width;
  logic [HOLD_CW-1:0]         hold_cnt;

  // Event summary including the sample of the current cycle.
  logic signed [DATA_W-1:0]   ev_max;
  logic [TIME_W-1:0]          ev_tmax;
  logic [WIDTH_W-1:0]         ev_width;
  logic                       ev_load;
  logic                       report;
  logic                       report_pile;

  logic                       above_live;
  logic                       above_lat;

  // Both operands are signed, so these are two's-complement comparisons.
  assign above_live = input_data > threshold;
  assign above_lat  = input_data > thr_l;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the running event summary for this cycle's sample.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next  = state;
    ev_max      = cur_max;
    ev_tmax     = cur_tmax;
    ev_width    = cur_width;
    ev_load     = 1'b0;
    report      = 1'b0;
    report_pile = 1'b0;

    case (state)
      ST_IDLE: begin
        if (above_live) begin
          ev_max   = input_data;
          ev_tmax  = ts;
          ev_width = WIDTH_W'(1);
          if (ev_width == MAX_W) begin
            // A limit of one sample terminates the event on its first sample.
            report      = 1'b1;
            report_pile = 1'b1;
            state_next  = POST_REPORT;
          end else begin
            ev_load    = 1'b1;
            state_next = ST_ARMED;
          end
        end
      end

      ST_ARMED: begin
        if (above_lat) begin
          ev_width = cur_width + WIDTH_W'(1);
          // Strict compare: on a plateau the earliest sample keeps the time.
          if (input_data > cur_max) begin
            ev_max  = input_data;
            ev_tmax = ts;
          end
          if (ev_width == MAX_W) begin
            report      = 1'b1;
            report_pile = 1'b1;
            state_next  = POST_REPORT;
          end else begin
            ev_load = 1'b1;
          end
        end else begin
          // The terminating sample is not part of the event.
          report     = 1'b1;
          state_next = POST_REPORT;
        end
      end

      ST_HOLDOFF: begin
        if (hold_cnt == '0) begin
          state_next = ST_REARM;
        end
      end

      ST_REARM: begin
        // Re-arm on the live threshold so a new event needs a clean rising edge.
        if (!above_live) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Free-running timestamp; the sample of a cycle carries that cycle's value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + TIME_W'(1);
    end
  end

  // Event tracking registers; the threshold is frozen while an event is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_l     <= '0;
      cur_max   <= '0;
      cur_tmax  <= '0;
      cur_width <= '0;
    end else begin
      if (state == ST_IDLE) begin
        thr_l <= threshold;
      end
      if (ev_load) begin
        cur_max   <= ev_max;
        cur_tmax  <= ev_tmax;
        cur_width <= ev_width;
      end
    end
  end

  // Dead-time counter, loaded on every report and run down in HOLDOFF.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (report) begin
      hold_cnt <= HOLD_LOAD;
    end else if (state == ST_HOLDOFF && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLD_CW'(1);
    end
  end

  // Result registers: one-cycle valid strobe, values held until the next report.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_valid  <= 1'b0;
      peak_amp    <= '0;
      peak_time   <= '0;
      peak_width  <= '0;
      pileup      <= 1'b0;
      event_count <= '0;
    end else begin
      peak_valid <= report;
      if (report) begin
        peak_amp    <= ev_max;
        peak_time   <= ev_tmax;
        peak_width  <= ev_width;
        pileup      <= report_pile;
        event_count <= event_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_peak_finder.sv
// Directed testbench for peak_finder (MAX_WIDTH=4, HOLDOFF=8).
// Samples are applied one per cycle; outputs are checked 1 ns after the edge
// that consumed the sample.
module tb_peak_finder;

  logic               clk;
  logic               reset;
  logic signed [15:0] input_data;
  logic signed [15:0] threshold;
  logic               peak_valid;
  logic signed [15:0] peak_amp;
  logic [15:0]        peak_time;
  logic [7:0]         peak_width;
  logic               pileup;
  logic [15:0]        event_count;

  int checks = 0;
  int errors = 0;

  // Samples for timestamps 15..29 of the hold-off scenario.
  logic signed [15:0] pulse2 [15] = '{16'sd90, 16'sd90, 16'sd500, 16'sd500, 16'sd90,
                                      16'sd90, 16'sd90, 16'sd90,  16'sd90,  16'sd90,
                                      16'sd90, 16'sd90, 16'sd200, 16'sd200, 16'sd50};

  peak_finder #(
    .DATA_W   (16),
    .TIME_W   (16),
    .WIDTH_W  (8),
    .HOLDOFF  (8),
    .MAX_WIDTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .input_data (input_data),
    .threshold  (threshold),
    .peak_valid (peak_valid),
    .peak_amp   (peak_amp),
    .peak_time  (peak_time),
    .peak_width (peak_width),
    .pileup     (pileup),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Present one sample, let the edge consume it, settle 1 ns past the edge.
  task automatic apply(input logic signed [15:0] d);
    input_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) apply(16'sd0);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    input_data = '0;
    threshold  = 16'sd100;

    // Reset state.
    do_reset();
    check("rst_valid", peak_valid, 0);
    check("rst_amp", peak_amp, 0);
    check("rst_time", peak_time, 0);
    check("rst_width", peak_width, 0);
    check("rst_pileup", pileup, 0);
    check("rst_count", event_count, 0);

    // Basic event: 50,150,300,250,90 at timestamps 10..14.
    repeat (10) apply(16'sd0);
    apply(16'sd50);
    apply(16'sd150);
    apply(16'sd300);
    apply(16'sd250);
    check("basic_no_early_valid", peak_valid, 0);
    apply(16'sd90);
    check("basic_valid", peak_valid, 1);
    check("basic_amp", peak_amp, 300);
    check("basic_time", peak_time, 12);
    check("basic_width", peak_width, 3);
    check("basic_pileup", pileup, 0);
    check("basic_count", event_count, 1);

    // Hold-off: pulse at ts17-18 ignored, pulse at ts27-28 reported.
    for (int i = 0; i < 14; i++) begin
      apply(pulse2[i]);
      check("holdoff_quiet", peak_valid, 0);
    end
    check("holdoff_amp_held", peak_amp, 300);
    check("holdoff_count_held", event_count, 1);
    apply(pulse2[14]);
    check("second_valid", peak_valid, 1);
    check("second_amp", peak_amp, 200);
    check("second_time", peak_time, 27);
    check("second_width", peak_width, 2);
    check("second_count", event_count, 2);

    // Pile-up: input held at 500 from ts0, limit of 4 samples.
    do_reset();
    repeat (3) apply(16'sd500);
    check("pile_no_early_valid", peak_valid, 0);
    apply(16'sd500);
    check("pile_valid", peak_valid, 1);
    check("pile_amp", peak_amp, 500);
    check("pile_time", peak_time, 0);
    check("pile_width", peak_width, 4);
    check("pile_flag", pileup, 1);
    check("pile_count", event_count, 1);
    // Input stays high through hold-off and beyond: no re-trigger (ts4..23).
    for (int i = 0; i < 20; i++) begin
      apply(16'sd500);
      check("pile_stuck_quiet", peak_valid, 0);
    end
    check("pile_stuck_count", event_count, 1);
    apply(16'sd50);   // ts24: re-arm
    apply(16'sd600);  // ts25: new event
    apply(16'sd50);   // ts26: terminate
    check("rearm_valid", peak_valid, 1);
    check("rearm_amp", peak_amp, 600);
    check("rearm_time", peak_time, 25);
    check("rearm_width", peak_width, 1);
    check("rearm_pileup_cleared", pileup, 0);
    check("rearm_count", event_count, 2);

    // Threshold raised mid-event; sample equal to threshold does not trigger.
    do_reset();
    threshold = 16'sd100;
    apply(16'sd100);  // ts0: equal, no trigger
    apply(16'sd200);  // ts1: start
    threshold = 16'sd1000;
    apply(16'sd400);  // ts2
    check("thr_no_early_valid", peak_valid, 0);
    apply(16'sd50);   // ts3: terminate against latched 100
    check("thr_valid", peak_valid, 1);
    check("thr_amp", peak_amp, 400);
    check("thr_time", peak_time, 2);
    check("thr_width", peak_width, 2);

    // Plateau keeps earliest time; sample equal to latched level terminates.
    do_reset();
    threshold = 16'sd100;
    apply(16'sd0);    // ts0
    apply(16'sd300);  // ts1
    apply(16'sd300);  // ts2
    apply(16'sd300);  // ts3
    apply(16'sd100);  // ts4: equal -> terminate
    check("plateau_valid", peak_valid, 1);
    check("plateau_amp", peak_amp, 300);
    check("plateau_time", peak_time, 1);
    check("plateau_width", peak_width, 3);
    check("plateau_pileup", pileup, 0);

    // Negative threshold: signed comparison.
    do_reset();
    threshold = -16'sd50;
    apply(-16'sd100); // ts0: below
    apply(16'sd10);   // ts1: start
    apply(-16'sd10);  // ts2: still above -50, smaller than 10
    apply(-16'sd60);  // ts3: terminate
    check("neg_valid", peak_valid, 1);
    check("neg_amp", peak_amp, 10);
    check("neg_time", peak_time, 1);
    check("neg_width", peak_width, 2);
    check("neg_count", event_count, 1);

    // Reset while ARMED aborts the event.
    threshold = 16'sd100;
    repeat (9) apply(16'sd0);  // ts4..12: hold-off, then re-arm
    apply(16'sd200);           // ts13: start
    apply(16'sd300);           // ts14
    reset = 1'b1;
    apply(16'sd50);            // would terminate, but reset wins
    check("abort_valid", peak_valid, 0);
    check("abort_amp", peak_amp, 0);
    check("abort_time", peak_time, 0);
    check("abort_width", peak_width, 0);
    check("abort_pileup", pileup, 0);
    check("abort_count", event_count, 0);
    reset = 1'b0;
    apply(16'sd0);    // ts0: first cycle evaluated in IDLE
    check("abort_still_quiet", peak_valid, 0);
    apply(16'sd150);  // ts1
    apply(16'sd0);    // ts2
    check("post_abort_valid", peak_valid, 1);
    check("post_abort_time", peak_time, 1);
    check("post_abort_amp", peak_amp, 150);
    check("post_abort_count", event_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
